sram_dma: RTL and testbench

Bus-master block-transfer engine for the 16-bit-address / 8-bit-data SRAM bus. It performs forward block copy (memory→memory) or block fill (constant→memory) and takes ownership of the bus via a request/acknowledge handshake with the CPU. It drives the same AD/DI/rw/cs signals the CPU normally drives into the SRAM interface, so it sits beside the CPU in front of the SRAM interface through the bus mux.

---
 rtl/sram_dma_pkg.sv | 19 +
 rtl/sram_dma.sv | 151 +++++++++++++++
 tb/tb_sram_dma.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dma_pkg.sv
// Shared types and constants for the SRAM block-transfer engine.
package sram_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/sram_dma.sv
// Bus-master block copy/fill engine for the 16-bit address / 8-bit data SRAM bus.
// Owns the bus through a bus_req/bus_ack handshake and can yield it between bytes.
module sram_dma
  import sram_dma_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_do,
  input  logic [DATA_W-1:0] mem_di,
  output logic              mem_rw,
  output logic              mem_cs
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              mode_q, mode_d;
  logic              wlast;

  assign wlast = (wcnt_q == WLAST);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = length;
          fill_d  = fill_data;
          state_d = (length == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_ack) begin
          wcnt_d  = '0;
          state_d = (mode_q == MODE_FILL) ? WR : RD;
        end
      end
      RD: begin
        if (wlast) begin
          data_d  = mem_di;
          wcnt_d  = '0;
          state_d = WR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      WR: begin
        if (wlast) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = GAP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      GAP: begin
        // Grant is only re-examined here, so a withdrawn ack parks the engine in REQ.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else if (bus_ack) begin
          wcnt_d  = '0;
          state_d = (mode_q == MODE_FILL) ? WR : RD;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bus_req <= 1'b0;
      mem_cs  <= 1'b0;
      mem_rw  <= 1'b1;
      mem_ad  <= '0;
      mem_do  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      bus_req <= (state_d inside {REQ, RD, WR, GAP});
      mem_cs  <= (state_d inside {RD, WR});
      mem_rw  <= (state_d != WR);
      case (state_d)
        RD: begin
          mem_ad <= src_d;
          mem_do <= '0;
        end
        WR: begin
          mem_ad <= dst_d;
          mem_do <= (mode_d == MODE_FILL) ? fill_d : data_d;
        end
        GAP: ;
        default: begin
          mem_ad <= '0;
          mem_do <= '0;
        end
      endcase
    end
  end

  // Transfer parameters only matter once launched, so they carry no reset.
  always_ff @(posedge clk) begin
    src_q  <= src_d;
    dst_q  <= dst_d;
    cnt_q  <= cnt_d;
    data_q <= data_d;
    fill_q <= fill_d;
    mode_q <= mode_d;
  end

endmodule

// File: tb/tb_sram_dma.sv
// Bench for sram_dma: SRAM model, directed table of transfers, random transfers,
// grant withdrawal, ignored restart and mid-transfer reset.
module tb_sram_dma;

  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst, start, mode, bus_ack;
  logic [15:0] src_addr, dst_addr, length;
  logic [7:0]  fill_data, mem_di, mem_do;
  logic        busy, done, bus_req, mem_rw, mem_cs;
  logic [15:0] mem_ad;

  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic        rw;
    logic [15:0] ad;
  } acc_t;

  typedef struct {
    bit          md;
    logic [15:0] s;
    logic [15:0] d;
    logic [15:0] n;
    logic [7:0]  f;
    int          exp_cyc;
    bit          drop;
    bit          poke;
  } vec_t;

  acc_t        acc_q[$];
  vec_t        tbl[7];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wr_commits = 0;
  logic        prv_cs = 1'b0;
  logic        prv_rw = 1'b1;
  logic [15:0] prv_ad = '0;
  logic [7:0]  prv_do = '0;

  sram_dma #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done),
    .bus_req(bus_req), .bus_ack(bus_ack),
    .mem_ad(mem_ad), .mem_do(mem_do), .mem_di(mem_di),
    .mem_rw(mem_rw), .mem_cs(mem_cs)
  );

  always #5 clk = ~clk;

  assign mem_di = mem[mem_ad];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the SRAM model: log access starts,
  // commit a write on the falling edge of cs.
  task automatic tick();
    @(negedge clk);
    if (mem_cs && (!prv_cs || prv_rw != mem_rw)) acc_q.push_back('{mem_rw, mem_ad});
    if (prv_cs && !mem_cs && !prv_rw) begin
      mem[prv_ad] = prv_do;
      wr_commits++;
    end
    prv_cs = mem_cs;
    prv_rw = mem_rw;
    prv_ad = mem_ad;
    prv_do = mem_do;
  endtask

  function automatic int xfer_cycles(input bit md, input int n);
    if (n == 0) return 1;
    return 2 + n * (md ? (WC + 1) : (2 * WC + 1));
  endfunction

  task automatic run_xfer(input bit md, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input logic [7:0] f, input int exp_cyc,
                          input bit drop, input bit poke);
    logic [7:0]  expb[$];
    acc_t        exp_acc[$];
    logic [15:0] a;
    logic [7:0]  pk_old;
    logic        exp_cs, exp_rw;
    int          per, cyc, done_cyc, pat_err, ph;
    bit          dropped;
    per = md ? (WC + 1) : (2 * WC + 1);
    for (int i = 0; i < int'(n); i++) begin
      a = s + 16'(i);
      expb.push_back(md ? f : mem[a]);
      if (!md) exp_acc.push_back('{1'b1, a});
      exp_acc.push_back('{1'b0, d + 16'(i)});
    end
    pk_old     = mem[16'hC000];
    acc_q.delete();
    wr_commits = 0;
    dropped    = 0;
    pat_err    = 0;
    done_cyc   = -1;

    start = 1'b1; mode = md; src_addr = s; dst_addr = d; length = n; fill_data = f;
    tick();
    cyc = 1;
    start = 1'b0; mode = ~md;
    src_addr = 16'($urandom); dst_addr = 16'($urandom);
    length = 16'($urandom); fill_data = 8'($urandom);
    chk("busy_rise", 32'(busy), 32'd1);
    chk("req_rise", 32'(bus_req), 32'(n != 0));

    while (cyc < 1000) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (!drop && n != 0) begin
        ph     = (cyc - 2) % per;
        exp_cs = (cyc >= 2) && (ph < per - 1);
        exp_rw = !exp_cs || (!md && ph < WC);
        if (bus_req !== 1'b1 || mem_cs !== exp_cs || mem_rw !== exp_rw) pat_err++;
      end
      if (drop && !dropped && wr_commits == 2) begin
        dropped = 1;
        bus_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          cyc++;
          chk("ack_low_cs", 32'(mem_cs), 32'd0);
          chk("ack_low_req", 32'(bus_req), 32'd1);
        end
        bus_ack = 1'b1;
      end
      if (poke && cyc == 3) begin
        start = 1'b1; mode = 1'b1; dst_addr = 16'hC000; length = 16'd2; fill_data = 8'hEE;
      end
      if (poke && cyc == 4) start = 1'b0;
      tick();
      cyc++;
    end

    chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
    if (!drop && n != 0) chk("bus_pattern_errs", 32'(pat_err), 32'd0);
    tick();
    chk("done_width", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("req_idle", 32'(bus_req), 32'd0);
    for (int i = 0; i < expb.size(); i++) chk("data", 32'(mem[d + 16'(i)]), 32'(expb[i]));
    chk("acc_count", 32'(acc_q.size()), 32'(exp_acc.size()));
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      chk("acc_rw_addr", 32'(acc_q[i]), 32'(exp_acc[i]));
    if (poke) chk("restart_ignored", 32'(mem[16'hC000]), 32'(pk_old));
  endtask

  task automatic reset_mid_copy();
    int  k;
    int  dcount;
    bit  hit;
    start = 1'b1; mode = 1'b0; src_addr = 16'h5000; dst_addr = 16'h6000;
    length = 16'd8; fill_data = 8'h00;
    tick();
    start = 1'b0;
    hit = 0;
    for (k = 1; k < 60; k++) begin
      if (k >= 4 && mem_cs === 1'b1 && mem_rw === 1'b1) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("rst_window_found", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_cs", 32'(mem_cs), 32'd0);
    chk("arst_rw", 32'(mem_rw), 32'd1);
    chk("arst_ad", 32'(mem_ad), 32'd0);
    chk("arst_do", 32'(mem_do), 32'd0);
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("no_done_after_rst", 32'(dcount), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit          md;
    logic [15:0] s, d, n;
    logic [7:0]  f;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h2000] = 8'h11;
    mem[16'h2001] = 8'h22;
    mem[16'h2002] = 8'h33;

    tbl[0] = '{1'b1, 16'h0000, 16'h1000, 16'd4, 8'hA5, 10, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h2000, 16'h3000, 16'd3, 8'h00, 11, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0000, 16'hFFFE, 16'd3, 8'h5C, 8,  1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h0000, 16'h7000, 16'd0, 8'h77, 1,  1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h0000, 16'h1100, 16'd4, 8'hC3, 15, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h2000, 16'h3100, 16'd3, 8'h00, 11, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 16'h2001, 16'h3200, 16'd1, 8'h00, 5,  1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; bus_ack = 1'b1;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_rw", 32'(mem_rw), 32'd1);
    chk("rst_ad", 32'(mem_ad), 32'd0);
    chk("rst_do", 32'(mem_do), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++)
      run_xfer(tbl[v].md, tbl[v].s, tbl[v].d, tbl[v].n, tbl[v].f,
               tbl[v].exp_cyc, tbl[v].drop, tbl[v].poke);

    for (int r = 0; r < 10; r++) begin
      md = 1'($urandom);
      s  = 16'h4000 + 16'($urandom_range(0, 16'h0FFF));
      d  = 16'h8000 + 16'($urandom_range(0, 16'h0FFF));
      n  = 16'($urandom_range(1, 16));
      f  = 8'($urandom);
      run_xfer(md, s, d, n, f, xfer_cycles(md, int'(n)), 1'b0, 1'b0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    reset_mid_copy();
    run_xfer(1'b0, 16'h5000, 16'h6800, 16'd5, 8'h00, xfer_cycles(1'b0, 5), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
